// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit core front end: PC width, default reset PC and
// the program-counter sequencer state encoding.
package cpu_pkg;

  localparam int unsigned PC_W = 16;
  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    StBoot   = 2'd0,
    StRun    = 2'd1,
    StFlush  = 2'd2,
    StHalted = 2'd3
  } seq_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous active-high clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {Width{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address owner: advances, holds or redirects the PC, squashes wrong-path fetches
// for a fixed number of cycles after a redirect, and counts taken branches.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter int unsigned     FLUSH_CYCLES = 2
) (
  input  logic            clk_pi,
  input  logic            reset_pi,
  input  logic            stall_pi,
  input  logic            halt_pi,
  input  logic            branch_valid_pi,
  input  logic            is_branch_taken_pi,
  input  logic [PC_W-1:0] branch_target_pi,
  input  logic            jump_pi,
  input  logic [PC_W-1:0] jump_target_pi,
  output logic [PC_W-1:0] pc_po,
  output logic            fetch_valid_po,
  output logic            flush_po,
  output logic            halted_po,
  output logic [7:0]      taken_count_po
);

  localparam int unsigned FlushCntW = 3;
  localparam logic [FlushCntW-1:0] FlushLoad = FlushCntW'(FLUSH_CYCLES - 1);

  seq_state_e           state_d, state_q;
  logic [PC_W-1:0]      pc_d, pc_q;
  logic [FlushCntW-1:0] flush_cnt_d, flush_cnt_q;
  logic                 taken_inc;
  logic                 branch_taken;

  assign branch_taken = branch_valid_pi & is_branch_taken_pi;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    flush_cnt_d = flush_cnt_q;
    taken_inc   = 1'b0;
    case (state_q)
      StBoot: begin
        state_d = halt_pi ? StHalted : StRun;
      end
      StRun: begin
        // The resolve-stage branch is older than the decode-stage jump, so it wins.
        if (halt_pi) begin
          state_d = StHalted;
        end else if (branch_taken) begin
          pc_d        = branch_target_pi;
          flush_cnt_d = FlushLoad;
          state_d     = StFlush;
          taken_inc   = 1'b1;
        end else if (jump_pi) begin
          pc_d        = jump_target_pi;
          flush_cnt_d = FlushLoad;
          state_d     = StFlush;
        end else if (!stall_pi) begin
          pc_d = pc_q + 1'b1;
        end
      end
      StFlush: begin
        // Branch and jump inputs here belong to the wrong path and are ignored.
        if (halt_pi) begin
          state_d = StHalted;
        end else if (flush_cnt_q == '0) begin
          state_d = StRun;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
        end
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      state_q     <= StBoot;
      pc_q        <= RESET_PC;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  sat_counter #(
    .Width(8)
  ) u_taken_count (
    .clk_i  (clk_pi),
    .rst_i  (reset_pi),
    .inc_i  (taken_inc),
    .count_o(taken_count_po)
  );

  assign pc_po          = pc_q;
  assign fetch_valid_po = (state_q == StRun) & ~stall_pi;
  assign flush_po       = (state_q == StFlush);
  assign halted_po      = (state_q == StHalted);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a per-cycle vector table plus hand-built sequences
// for saturation, halt during flush and reset recovery.
module tb_pc_sequencer;

  localparam logic [15:0] RstPc = 16'h0100;

  logic        clk;
  logic        reset, stall, halt, bvalid, btaken, jump;
  logic [15:0] btgt, jtgt;
  logic [15:0] pc;
  logic        fetch_valid, flush, halted;
  logic [7:0]  taken_count;

  typedef struct {
    bit          chk;
    logic        rst, stl, hlt, bv, bt;
    logic [15:0] btg;
    logic        jmp;
    logic [15:0] jtg;
    logic [15:0] e_pc;
    logic        e_fv, e_fl, e_hl;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t  tbl[$];
  vec_t  exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  string phase = "init";

  pc_sequencer #(
    .RESET_PC    (RstPc),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk_pi            (clk),
    .reset_pi          (reset),
    .stall_pi          (stall),
    .halt_pi           (halt),
    .branch_valid_pi   (bvalid),
    .is_branch_taken_pi(btaken),
    .branch_target_pi  (btgt),
    .jump_pi           (jump),
    .jump_target_pi    (jtgt),
    .pc_po             (pc),
    .fetch_valid_po    (fetch_valid),
    .flush_po          (flush),
    .halted_po         (halted),
    .taken_count_po    (taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(bit chk, logic rst, logic stl, logic hlt, logic bv, logic bt,
                              logic [15:0] btg, logic jmp, logic [15:0] jtg,
                              logic [15:0] e_pc, logic e_fv, logic e_fl, logic e_hl,
                              logic [7:0] e_cnt);
    vec_t v;
    v.chk = chk; v.rst = rst; v.stl = stl; v.hlt = hlt; v.bv = bv; v.bt = bt;
    v.btg = btg; v.jmp = jmp; v.jtg = jtg;
    v.e_pc = e_pc; v.e_fv = e_fv; v.e_fl = e_fl; v.e_hl = e_hl; v.e_cnt = e_cnt;
    return v;
  endfunction

  // Plain cycle with no events: only expected outputs vary.
  function automatic vec_t idle(logic stl, logic [15:0] e_pc, logic e_fv, logic e_fl,
                                logic e_hl, logic [7:0] e_cnt);
    return mk(1, 0, stl, 0, 0, 0, 16'h0, 0, 16'h0, e_pc, e_fv, e_fl, e_hl, e_cnt);
  endfunction

  task automatic check_front();
    vec_t e;
    e = exp_q.pop_front();
    if (!e.chk) return;
    n_checks += 5;
    if (pc !== e.e_pc) begin
      n_errors++;
      $display("FAIL %s cyc %0d pc: got %h want %h", phase, cyc, pc, e.e_pc);
    end
    if (fetch_valid !== e.e_fv) begin
      n_errors++;
      $display("FAIL %s cyc %0d fetch_valid: got %b want %b", phase, cyc, fetch_valid, e.e_fv);
    end
    if (flush !== e.e_fl) begin
      n_errors++;
      $display("FAIL %s cyc %0d flush: got %b want %b", phase, cyc, flush, e.e_fl);
    end
    if (halted !== e.e_hl) begin
      n_errors++;
      $display("FAIL %s cyc %0d halted: got %b want %b", phase, cyc, halted, e.e_hl);
    end
    if (taken_count !== e.e_cnt) begin
      n_errors++;
      $display("FAIL %s cyc %0d taken_count: got %h want %h", phase, cyc, taken_count,
               e.e_cnt);
    end
  endtask

  // Drive one cycle of inputs just after the edge, check outputs mid-cycle.
  task automatic step(input vec_t v);
    reset = v.rst; stall = v.stl; halt = v.hlt; bvalid = v.bv; btaken = v.bt;
    btgt = v.btg; jump = v.jmp; jtgt = v.jtg;
    exp_q.push_back(v);
    @(negedge clk);
    check_front();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic [15:0] exp_pc;
    logic [15:0] tgt;
    logic [7:0]  cnt;

    reset = 1'b1; stall = 1'b0; halt = 1'b0; bvalid = 1'b0; btaken = 1'b0; jump = 1'b0;
    btgt = '0; jtgt = '0;
    @(posedge clk);
    #1;

    // Columns: chk rst stl hlt bv bt btg jmp jtg | pc fv fl hl cnt
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0100, 0, 0, 0, 8'd0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0100, 0, 0, 0, 8'd0));
    tbl.push_back(idle(0, 16'h0100, 0, 0, 0, 8'd0));
    tbl.push_back(idle(0, 16'h0100, 1, 0, 0, 8'd0));
    tbl.push_back(idle(0, 16'h0101, 1, 0, 0, 8'd0));
    tbl.push_back(idle(0, 16'h0102, 1, 0, 0, 8'd0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 16'h0040, 0, 16'h0000, 16'h0103, 1, 0, 0, 8'd0));
    tbl.push_back(idle(0, 16'h0040, 0, 1, 0, 8'd1));
    tbl.push_back(idle(0, 16'h0040, 0, 1, 0, 8'd1));
    tbl.push_back(idle(0, 16'h0040, 1, 0, 0, 8'd1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 16'h0200, 1, 16'h0300, 16'h0041, 1, 0, 0, 8'd1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 16'h0500, 1, 16'h0600, 16'h0200, 0, 1, 0, 8'd2));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 16'h0700, 0, 16'h0000, 16'h0200, 0, 1, 0, 8'd2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 16'h0000, 1, 16'hFFFE, 16'h0200, 1, 0, 0, 8'd2));
    tbl.push_back(idle(0, 16'hFFFE, 0, 1, 0, 8'd2));
    tbl.push_back(idle(0, 16'hFFFE, 0, 1, 0, 8'd2));
    tbl.push_back(idle(0, 16'hFFFE, 1, 0, 0, 8'd2));
    tbl.push_back(idle(0, 16'hFFFF, 1, 0, 0, 8'd2));
    tbl.push_back(idle(1, 16'h0000, 0, 0, 0, 8'd2));
    tbl.push_back(idle(1, 16'h0000, 0, 0, 0, 8'd2));
    tbl.push_back(idle(0, 16'h0000, 1, 0, 0, 8'd2));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 16'h0900, 0, 16'h0000, 16'h0001, 1, 0, 0, 8'd2));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 16'h0900, 0, 16'h0000, 16'h0002, 1, 0, 0, 8'd2));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 16'h0000, 1, 16'h0010, 16'h0003, 0, 0, 0, 8'd2));
    tbl.push_back(idle(0, 16'h0010, 0, 1, 0, 8'd2));
    tbl.push_back(idle(1, 16'h0010, 0, 1, 0, 8'd2));
    tbl.push_back(mk(1, 0, 0, 1, 1, 1, 16'h0777, 0, 16'h0000, 16'h0010, 1, 0, 0, 8'd2));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 16'h0888, 1, 16'h0999, 16'h0010, 0, 0, 1, 8'd2));
    tbl.push_back(idle(0, 16'h0010, 0, 0, 1, 8'd2));

    phase = "table";
    foreach (tbl[i]) step(tbl[i]);

    // Saturation: 300 taken branches, then 5 not-taken ones.
    phase = "saturate";
    step(mk(1, 1, 0, 0, 0, 0, 16'h0, 0, 16'h0, 16'h0010, 0, 0, 1, 8'd2));
    step(mk(1, 1, 0, 0, 0, 0, 16'h0, 0, 16'h0, RstPc, 0, 0, 0, 8'd0));
    step(idle(0, RstPc, 0, 0, 0, 8'd0));
    exp_pc = RstPc;
    for (int k = 0; k < 300; k++) begin
      tgt = 16'h1000 + 16'(k);
      cnt = (k >= 255) ? 8'hFF : 8'(k);
      step(mk(1, 0, 0, 0, 1, 1, tgt, 0, 16'h0, exp_pc, 1, 0, 0, cnt));
      cnt = (k + 1 >= 255) ? 8'hFF : 8'(k + 1);
      step(idle(0, tgt, 0, 1, 0, cnt));
      step(idle(0, tgt, 0, 1, 0, cnt));
      exp_pc = tgt;
    end
    for (int k = 0; k < 5; k++) begin
      step(mk(1, 0, 0, 0, 1, 0, 16'h2000, 0, 16'h0, exp_pc, 1, 0, 0, 8'hFF));
      exp_pc = exp_pc + 16'd1;
    end
    step(idle(0, exp_pc, 1, 0, 0, 8'hFF));
    exp_pc = exp_pc + 16'd1;

    // Halt in the first FLUSH cycle freezes the target PC; later events are ignored.
    phase = "halt_flush";
    step(mk(1, 0, 0, 0, 0, 0, 16'h0, 1, 16'h0ABC, exp_pc, 1, 0, 0, 8'hFF));
    step(mk(1, 0, 0, 1, 0, 0, 16'h0, 0, 16'h0, 16'h0ABC, 0, 1, 0, 8'hFF));
    step(mk(1, 0, 0, 0, 1, 1, 16'h0123, 0, 16'h0, 16'h0ABC, 0, 0, 1, 8'hFF));
    step(mk(1, 0, 0, 0, 0, 0, 16'h0, 1, 16'h0456, 16'h0ABC, 0, 0, 1, 8'hFF));
    step(idle(0, 16'h0ABC, 0, 0, 1, 8'hFF));

    // Reset out of HALTED, then halt straight from BOOT.
    phase = "reset_halted";
    step(mk(1, 1, 0, 0, 0, 0, 16'h0, 0, 16'h0, 16'h0ABC, 0, 0, 1, 8'hFF));
    step(mk(1, 1, 0, 0, 0, 0, 16'h0, 0, 16'h0, RstPc, 0, 0, 0, 8'd0));
    step(mk(1, 0, 0, 1, 0, 0, 16'h0, 0, 16'h0, RstPc, 0, 0, 0, 8'd0));
    step(idle(0, RstPc, 0, 0, 1, 8'd0));

    // Reset in the middle of FLUSH.
    phase = "reset_flush";
    step(mk(1, 1, 0, 0, 0, 0, 16'h0, 0, 16'h0, RstPc, 0, 0, 1, 8'd0));
    step(idle(0, RstPc, 0, 0, 0, 8'd0));
    step(mk(1, 0, 0, 0, 1, 1, 16'h0222, 0, 16'h0, RstPc, 1, 0, 0, 8'd0));
    step(mk(1, 1, 0, 0, 0, 0, 16'h0, 0, 16'h0, 16'h0222, 0, 1, 0, 8'd1));
    step(idle(0, RstPc, 0, 0, 0, 8'd0));
    step(idle(0, RstPc, 1, 0, 0, 8'd0));
    step(idle(0, 16'h0101, 1, 0, 0, 8'd0));

    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard: %0d entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the 16-bit core: owns the fetch address and consumes the branch-taken decision produced by the resolve-stage branch comparator. Each cycle it advances, holds, or redirects the PC. After a redirect it squashes wrong-path fetches for a fixed number of cycles. It also reports halt status and a saturating count of taken branches for debug/perf.

## Interface
Parameters:
- RESET_PC, 16'h0000, fetch address loaded on reset
- FLUSH_CYCLES, 2, bubble cycles after any redirect; legal range 1..7

Ports:
- clk_pi  in  1  core clock; all state changes on rising edge
- reset_pi  in  1  synchronous, active-high reset
- stall_pi  in  1  downstream not accepting; hold PC
- halt_pi  in  1  enter HALTED
- branch_valid_pi  in  1  resolve stage holds a conditional branch this cycle
- is_branch_taken_pi  in  1  comparator result; meaningful only with branch_valid_pi
- branch_target_pi  in  16  conditional branch target
- jump_pi  in  1  decode-stage unconditional jump
- jump_target_pi  in  16  jump target
- pc_po  out  16  current fetch address
- fetch_valid_po  out  1  pc_po is a real fetch this cycle
- flush_po  out  1  squash younger instructions in fetch/decode
- halted_po  out  1  sequencer halted
- taken_count_po  out  8  saturating count of taken conditional branches

## Operation
- States: BOOT, RUN, FLUSH, HALTED. Reset enters BOOT.
- BOOT: one cycle. Next state is HALTED if halt_pi, else RUN. PC holds RESET_PC.
- RUN evaluates one event per cycle, in priority order:
  - halt_pi -> HALTED; PC holds.
  - Taken branch (branch_valid_pi & is_branch_taken_pi) -> pc <= branch_target_pi, load flush counter, go to FLUSH, taken_count += 1.
    - The branch is older than a decode-stage jump, so it beats jump_pi.
  - jump_pi -> pc <= jump_target_pi, load flush counter, go to FLUSH. Not counted.
  - stall_pi -> PC holds.
  - Otherwise pc <= pc + 1. Word addressing; wraps 16'hFFFF -> 16'h0000.
- Redirects are not blocked by stall_pi.
- FLUSH:
  - Counter loaded with FLUSH_CYCLES-1 on entry and decremented each cycle. Returns to RUN in the cycle after the counter reads 0, so FLUSH lasts exactly FLUSH_CYCLES cycles.
  - PC holds the target.
  - branch_valid_pi, is_branch_taken_pi and jump_pi are ignored (wrong path).
  - halt_pi -> HALTED immediately.
- HALTED: absorbing. PC holds. Exit only via reset_pi.
- Output decode:
  - fetch_valid_po = (state==RUN) & ~stall_pi.
  - flush_po = (state==FLUSH).
  - halted_po = (state==HALTED).
- taken_count_po saturates at 8'hFF with no wrap. A not-taken branch (branch_valid_pi=1, is_branch_taken_pi=0) has no effect beyond a normal RUN step.

## Timing
- Reset values, held while reset_pi=1 and in the first cycle after release:
  - pc_po = RESET_PC
  - fetch_valid_po = 0, flush_po = 0, halted_po = 0
  - taken_count_po = 0
  - state BOOT, flush counter 0
- The first fetch_valid_po=1 occurs 1 cycle after reset deasserts (BOOT cycle).
- Redirect latency:
  - Event sampled at edge N.
  - pc_po = target and flush_po = 1 from cycle N+1 through N+FLUSH_CYCLES.
  - fetch_valid_po = 1 at target from cycle N+FLUSH_CYCLES+1, provided there is no stall.
- Branch/jump inputs in the same cycle as halt_pi are dropped.
- Reset mid-FLUSH or in HALTED returns to BOOT on the next edge. The counter and taken_count are cleared.
- All outputs are registered or decoded from registered state only; no input-to-output combinational path except stall_pi -> fetch_valid_po.

## Structure
- Shared package cpu_pkg: state enum (BOOT, RUN, FLUSH, HALTED), PC_W = 16, default RESET_PC.
- One sub-module: sat_counter (width parameter, sync reset, increment enable, saturate at all-ones). Used for taken_count_po.
- The flush counter is an inline 3-bit down-counter.

## Test plan
- Reset with RESET_PC=16'h0100, no stalls for 4 cycles -> BOOT cycle has fetch_valid=0; then pc 0100, 0101, 0102 with fetch_valid=1.
- Taken branch at pc 0103, target 16'h0040, FLUSH_CYCLES=2 -> flush=1 for 2 cycles with pc=0040; then fetch 0040, 0041; taken_count=1.
- Same cycle: branch taken to 16'h0200 plus jump to 16'h0300 -> pc=0200; a second branch asserted during FLUSH is ignored; taken_count increments once.
- PC at 16'hFFFF, no events -> next pc 16'h0000; with stall_pi=1 -> pc holds and fetch_valid=0.
- 300 taken branches -> taken_count_po stops at 8'hFF; 5 not-taken branches -> no flush and no count change.
- halt_pi mid-FLUSH -> halted=1 and flush=0 next cycle, pc frozen; later branches/jumps ignored; reset_pi -> pc=RESET_PC, all outputs at reset values.
